// File: rtl/hole_event_sequencer.sv
// Round controller for the hole-drop game: arms the detector, runs the fall animation, tracks lives/level.
// Optional `FALL_SHRINK_EN`: shrink the fall sprite by one pixel per counted frame tick.
module hole_event_sequencer #(
   parameter int RADIUS      = 16,
   parameter int LIVES       = 3,
   parameter int FALL_FRAMES = 16,
   parameter int NUM_LEVELS  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_frame_tick,
   input  logic       i_start,
   input  logic       i_win,
   input  logic       i_fail,
   input  logic [9:0] i_pos_fall_x,
   input  logic [9:0] i_pos_fall_y,
   output logic       o_game_playing,
   output logic       o_ball_load,
   output logic       o_fall_active,
   output logic [9:0] o_fall_x,
   output logic [9:0] o_fall_y,
   output logic [5:0] o_fall_radius,
   output logic [3:0] o_lives,
   output logic [3:0] o_level,
   output logic       o_game_over,
   output logic       o_game_won,
   output logic [2:0] o_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      PLAY   = 3'd2,
      FALL   = 3'd3,
      RESULT = 3'd4,
      OVER   = 3'd5
   } state_t;

   localparam logic [5:0] RADIUS_V     = 6'(RADIUS);
   localparam logic [3:0] LIVES_V      = 4'(LIVES);
   localparam logic [7:0] FRAMES_V     = 8'(FALL_FRAMES);
   localparam logic [3:0] LAST_LEVEL_V = 4'(NUM_LEVELS - 1);

   state_t     state, state_next;
   logic       armed, armed_next;
   logic       fall_win, fall_win_next;
   logic [7:0] frame_cnt, frame_cnt_next, frame_cnt_inc;
   logic [9:0] fall_x, fall_x_next;
   logic [9:0] fall_y, fall_y_next;
   logic [5:0] radius, radius_next;
   logic [3:0] lives, lives_next;
   logic [3:0] level, level_next;
   logic       game_over, game_over_next;
   logic       game_won, game_won_next;
   logic       ball_load, game_playing, fall_active;

   assign frame_cnt_inc = frame_cnt + 8'd1;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath update for every round phase
   always_comb begin
      state_next     = state;
      armed_next     = armed;
      fall_win_next  = fall_win;
      frame_cnt_next = frame_cnt;
      fall_x_next    = fall_x;
      fall_y_next    = fall_y;
      radius_next    = radius;
      lives_next     = lives;
      level_next     = level;
      game_over_next = game_over;
      game_won_next  = game_won;

      case (state)
         IDLE, OVER: begin
            if (i_start) begin
               state_next     = LOAD;
               lives_next     = LIVES_V;
               level_next     = 4'd0;
               game_over_next = 1'b0;
               game_won_next  = 1'b0;
            end else begin
               state_next = state;
            end
         end
         LOAD: begin
            armed_next = 1'b0;
            state_next = PLAY;
         end
         PLAY: begin
            // The detector flag can be stale right after a reload, so wait one frame first
            if (!armed) begin
               armed_next = i_frame_tick;
            end else if (i_win || i_fail) begin
               fall_x_next    = i_pos_fall_x;
               fall_y_next    = i_pos_fall_y;
               fall_win_next  = i_win;
               radius_next    = RADIUS_V;
               frame_cnt_next = 8'd0;
               state_next     = FALL;
            end else begin
               state_next = PLAY;
            end
         end
         FALL: begin
            if (i_frame_tick) begin
               frame_cnt_next = frame_cnt_inc;
`ifdef FALL_SHRINK_EN
               radius_next = (radius == 6'd0) ? 6'd0 : radius - 6'd1;
`else
               radius_next = radius;
`endif
               if (frame_cnt_inc == FRAMES_V) begin
                  radius_next = 6'd0;
                  state_next  = RESULT;
               end else begin
                  state_next = FALL;
               end
            end else begin
               state_next = FALL;
            end
         end
         RESULT: begin
            radius_next = 6'd0;
            if (fall_win) begin
               if (level >= LAST_LEVEL_V) begin
                  game_won_next = 1'b1;
                  state_next    = OVER;
               end else begin
                  level_next = level + 4'd1;
                  state_next = LOAD;
               end
            end else begin
               if (lives <= 4'd1) begin
                  lives_next     = 4'd0;
                  game_over_next = 1'b1;
                  state_next     = OVER;
               end else begin
                  lives_next = lives - 4'd1;
                  state_next = LOAD;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and registered output decode
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         armed        <= 1'b0;
         fall_win     <= 1'b0;
         frame_cnt    <= 8'd0;
         fall_x       <= 10'd0;
         fall_y       <= 10'd0;
         radius       <= 6'd0;
         lives        <= LIVES_V;
         level        <= 4'd0;
         game_over    <= 1'b0;
         game_won     <= 1'b0;
         ball_load    <= 1'b0;
         game_playing <= 1'b0;
         fall_active  <= 1'b0;
      end else begin
         armed        <= armed_next;
         fall_win     <= fall_win_next;
         frame_cnt    <= frame_cnt_next;
         fall_x       <= fall_x_next;
         fall_y       <= fall_y_next;
         radius       <= radius_next;
         lives        <= lives_next;
         level        <= level_next;
         game_over    <= game_over_next;
         game_won     <= game_won_next;
         ball_load    <= (state_next == LOAD);
         game_playing <= (state_next == PLAY);
         fall_active  <= (state_next == FALL);
      end
   end

   assign o_game_playing = game_playing;
   assign o_ball_load    = ball_load;
   assign o_fall_active  = fall_active;
   assign o_fall_x       = fall_x;
   assign o_fall_y       = fall_y;
   assign o_fall_radius  = radius;
   assign o_lives        = lives;
   assign o_level        = level;
   assign o_game_over    = game_over;
   assign o_game_won     = game_won;
   assign o_state        = state;

endmodule
